mips_pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the 5-stage MIPS core. It owns the PC and the ID/EX/MEM/WB instruction registers, and detects hazards. It stalls only one bubble on load-use, forwards ALU results, and squashes on branch/jump redirect. It also supports a run/single-step mode for board debugging. It sits between the instruction ROM, the EX-stage ALU/branch unit and the register bank, and replaces the ad-hoc control in the core top level.

---
 rtl/mips_pipe_ctrl_if.sv | 36 +++
 rtl/mips_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_ctrl_if.sv
// Pipeline-controller bus: fetch, redirect, stage IRs, forwarding and write-back signals.
// master = controller side, slave = core/ROM/environment side.
interface mips_pipe_ctrl_if #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 16
);
    logic                 run;
    logic                 step;
    logic [31:0]          inst_in;
    logic                 redirect_valid;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic [PC_WIDTH-1:0]  pc_out;
    logic [31:0]          id_ir;
    logic [31:0]          ex_ir;
    logic [31:0]          mem_ir;
    logic [31:0]          wb_ir;
    logic [PC_WIDTH-1:0]  ex_pc;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic                 stall_out;
    logic                 wb_en;
    logic [4:0]           wb_dest;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  run, step, inst_in, redirect_valid, redirect_pc,
        output pc_out, id_ir, ex_ir, mem_ir, wb_ir, ex_pc,
               fwd_a, fwd_b, stall_out, wb_en, wb_dest, retired
    );

    modport slave (
        output run, step, inst_in, redirect_valid, redirect_pc,
        input  pc_out, id_ir, ex_ir, mem_ir, wb_ir, ex_pc,
               fwd_a, fwd_b, stall_out, wb_en, wb_dest, retired
    );
endinterface

// File: rtl/mips_pipe_ctrl.sv
// 5-stage MIPS pipeline controller: PC, ID/EX/MEM/WB IRs, forwarding, load-use stall, redirect squash.
// Latency: fetch to wb_ir in 4 advance cycles; load-use adds 1 bubble, redirect adds 2.
// Backpressure: none; run/step gate every register, stall holds pc and id_ir only.
module mips_pipe_ctrl #(
    parameter int PC_WIDTH  = 10,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    mips_pipe_ctrl_if.master bus
);

    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_J
    } cls_t;

    function automatic cls_t op_class(input logic [31:0] ir);
        cls_t c;
        c = C_NONE;
        case (ir[31:26])
            6'h00:   if (ir[5:0] == 6'h20 || ir[5:0] == 6'h22) c = C_ALU;
            6'h08:   c = C_ADDI;
            6'h23:   c = C_LW;
            6'h2B:   c = C_SW;
            6'h04:   c = C_BEQ;
            6'h02:   c = C_J;
            default: c = C_NONE;
        endcase
        return c;
    endfunction

    // Source/destination helpers return 0 for "none", since $0 never creates a hazard.
    function automatic logic [4:0] src_a(input logic [31:0] ir);
        cls_t c;
        c = op_class(ir);
        return (c == C_NONE || c == C_J) ? 5'd0 : ir[25:21];
    endfunction

    function automatic logic [4:0] src_b(input logic [31:0] ir);
        cls_t c;
        c = op_class(ir);
        return (c == C_ALU || c == C_SW || c == C_BEQ) ? ir[20:16] : 5'd0;
    endfunction

    function automatic logic [4:0] dst(input logic [31:0] ir);
        cls_t c;
        c = op_class(ir);
        if (c == C_ALU)                    return ir[15:11];
        else if (c == C_ADDI || c == C_LW) return ir[20:16];
        else                               return 5'd0;
    endfunction

    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_id_pc;
    logic [PC_WIDTH-1:0]  r_ex_pc;
    logic [31:0]          r_id_ir;
    logic [31:0]          r_ex_ir;
    logic [31:0]          r_mem_ir;
    logic [31:0]          r_wb_ir;
    logic [CNT_WIDTH-1:0] r_retired;

    logic       w_adv;
    logic       w_ld_use;
    logic [4:0] w_ex_dst;
    logic [4:0] w_mem_dst;
    logic [4:0] w_wb_dst;
    logic [4:0] w_ex_ra;
    logic [4:0] w_ex_rb;
    logic [4:0] w_id_ra;
    logic [4:0] w_id_rb;

    assign w_adv     = bus.run | bus.step;
    assign w_ex_dst  = dst(r_ex_ir);
    assign w_mem_dst = dst(r_mem_ir);
    assign w_wb_dst  = dst(r_wb_ir);
    assign w_ex_ra   = src_a(r_ex_ir);
    assign w_ex_rb   = src_b(r_ex_ir);
    assign w_id_ra   = src_a(r_id_ir);
    assign w_id_rb   = src_b(r_id_ir);

    assign w_ld_use = (op_class(r_ex_ir) == C_LW) && (w_ex_dst != 5'd0) &&
                      ((w_id_ra == w_ex_dst) || (w_id_rb == w_ex_dst));

    // A load in MEM has no result yet; it is only forwardable once it reaches WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic mem_is_lw,
                                           input logic [4:0] mem_dst, input logic [4:0] wb_dst);
        if (r == 5'd0)                      return 2'b00;
        else if (mem_dst == r && !mem_is_lw) return 2'b01;
        else if (wb_dst == r)               return 2'b10;
        else                                return 2'b00;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc      <= PC_RST;
            r_id_pc   <= PC_RST;
            r_ex_pc   <= PC_RST;
            r_id_ir   <= '0;
            r_ex_ir   <= '0;
            r_mem_ir  <= '0;
            r_wb_ir   <= '0;
            r_retired <= '0;
        end else if (w_adv) begin
            r_mem_ir <= r_ex_ir;
            r_wb_ir  <= r_mem_ir;
            if (op_class(r_wb_ir) != C_NONE && r_retired != '1)
                r_retired <= r_retired + CNT_WIDTH'(1);
            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_pc;
                r_id_ir <= '0;
                r_ex_ir <= '0;
            end else if (w_ld_use) begin
                r_ex_ir <= '0;
            end else begin
                r_pc    <= r_pc + PC_WIDTH'(1);
                r_id_pc <= r_pc;
                r_id_ir <= bus.inst_in;
                r_ex_ir <= r_id_ir;
                r_ex_pc <= r_id_pc;
            end
        end
    end

    assign bus.pc_out    = r_pc;
    assign bus.id_ir     = r_id_ir;
    assign bus.ex_ir     = r_ex_ir;
    assign bus.mem_ir    = r_mem_ir;
    assign bus.wb_ir     = r_wb_ir;
    assign bus.ex_pc     = r_ex_pc;
    assign bus.fwd_a     = fwd_sel(w_ex_ra, op_class(r_mem_ir) == C_LW, w_mem_dst, w_wb_dst);
    assign bus.fwd_b     = fwd_sel(w_ex_rb, op_class(r_mem_ir) == C_LW, w_mem_dst, w_wb_dst);
    assign bus.stall_out = w_ld_use;
    assign bus.wb_en     = (w_wb_dst != 5'd0);
    assign bus.wb_dest   = w_wb_dst;
    assign bus.retired   = r_retired;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Self-checking bench for mips_pipe_ctrl: scoreboard on the write-back stream plus directed hazard checks.
module tb_mips_pipe_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mips_pipe_ctrl_if #(.PC_WIDTH(10), .CNT_WIDTH(16)) bus ();
    mips_pipe_ctrl_if #(.PC_WIDTH(4),  .CNT_WIDTH(16)) bus4 ();

    mips_pipe_ctrl #(.PC_WIDTH(10), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    mips_pipe_ctrl #(.PC_WIDTH(4), .RESET_PC(0), .CNT_WIDTH(16)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.master)
    );

    logic [31:0] rom [0:1023];
    assign bus.inst_in  = rom[bus.pc_out];
    assign bus4.inst_in = 32'h0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        last_adv = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Scoreboard: every advance that lands a non-zero instruction in WB must match the next expected one.
    always @(posedge clock) last_adv = reset & (bus.run | bus.step);

    always @(negedge clock) begin
        if (reset && last_adv && bus.wb_ir != 32'h0) begin
            if (exp_q.size() == 0) check_val("wb_extra", bus.wb_ir, 32'h0);
            else                   check_val("wb_ir", bus.wb_ir, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        bus.run = 1'b0; bus.step = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus4.run = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("rst_pc", bus.pc_out, 0);
        check_val("rst_ex_pc", bus.ex_pc, 0);
        check_val("rst_id", bus.id_ir, 0);
        check_val("rst_ex", bus.ex_ir, 0);
        check_val("rst_mem", bus.mem_ir, 0);
        check_val("rst_wb", bus.wb_ir, 0);
        check_val("rst_ret", bus.retired, 0);
        check_val("rst_fwd", {bus.fwd_a, bus.fwd_b}, 0);
        check_val("rst_stall", bus.stall_out, 0);
        check_val("rst_wb_en", bus.wb_en, 0);
        check_val("rst_wb_dest", bus.wb_dest, 0);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        reset = 1'b0;
        bus4.step = 1'b0; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0; bus4.run = 1'b0;

        // Forwarding chain: addi $1,$0,5; add $2,$1,$1; sub $3,$2,$1
        do_reset();
        rom[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
        rom[1] = r_type(5'd1, 5'd1, 5'd2, 6'h20);
        rom[2] = r_type(5'd2, 5'd1, 5'd3, 6'h22);
        for (int k = 0; k < 3; k++) exp_q.push_back(rom[k]);
        bus.run = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check_val("fc_stall", bus.stall_out, 0);
            if (e == 3) begin
                check_val("fc_add_fa", bus.fwd_a, 2'b01);
                check_val("fc_add_fb", bus.fwd_b, 2'b01);
            end
            if (e == 4) begin
                check_val("fc_sub_fa", bus.fwd_a, 2'b01);
                check_val("fc_sub_fb", bus.fwd_b, 2'b10);
                check_val("fc_wb_en", bus.wb_en, 1);
                check_val("fc_wb_dest1", bus.wb_dest, 1);
            end
            if (e == 6) check_val("fc_wb_dest3", bus.wb_dest, 3);
        end
        check_val("fc_retired", bus.retired, 3);
        check_val("fc_sb_left", exp_q.size(), 0);

        // Load-use: lw $4,0($0); add $5,$4,$4
        do_reset();
        rom[0] = i_type(6'h23, 5'd0, 5'd4, 16'd0);
        rom[1] = r_type(5'd4, 5'd4, 5'd5, 6'h20);
        exp_q.push_back(rom[0]);
        exp_q.push_back(rom[1]);
        bus.run = 1'b1;
        stalls = 0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            if (bus.stall_out) stalls++;
            if (e == 2) begin
                check_val("lu_pc_e2", bus.pc_out, 2);
                check_val("lu_stall_e2", bus.stall_out, 1);
            end
            if (e == 3) begin
                check_val("lu_pc_held", bus.pc_out, 2);
                check_val("lu_ex_bubble", bus.ex_ir, 0);
                check_val("lu_id_held", bus.id_ir, rom[1]);
            end
            if (e == 4) begin
                check_val("lu_ex_add", bus.ex_ir, rom[1]);
                check_val("lu_fa", bus.fwd_a, 2'b10);
                check_val("lu_fb", bus.fwd_b, 2'b10);
            end
        end
        check_val("lu_stalls", stalls, 1);
        check_val("lu_retired", bus.retired, 2);
        check_val("lu_sb_left", exp_q.size(), 0);

        // Redirect from PC 0x05 to 0x20
        do_reset();
        for (int k = 0; k < 3; k++) rom[k] = i_type(6'h08, 5'd0, 5'(k + 1), 16'(k));
        rom[3]    = i_type(6'h04, 5'd0, 5'd0, 16'h001c);
        rom[4]    = i_type(6'h08, 5'd0, 5'd7, 16'd7);
        rom[5]    = i_type(6'h08, 5'd0, 5'd8, 16'd8);
        rom[6'h20] = i_type(6'h08, 5'd0, 5'd9, 16'd9);
        rom[6'h21] = i_type(6'h08, 5'd0, 5'd10, 16'd10);
        for (int k = 0; k < 4; k++) exp_q.push_back(rom[k]);
        exp_q.push_back(rom[6'h20]);
        exp_q.push_back(rom[6'h21]);
        bus.run = 1'b1;
        tick(5);
        check_val("rd_pc_pre", bus.pc_out, 5);
        check_val("rd_ex_beq", bus.ex_ir, rom[3]);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h020;
        tick(1);
        bus.redirect_valid = 1'b0;
        check_val("rd_pc", bus.pc_out, 10'h020);
        check_val("rd_id_sq", bus.id_ir, 0);
        check_val("rd_ex_sq", bus.ex_ir, 0);
        check_val("rd_mem_beq", bus.mem_ir, rom[3]);
        tick(1);
        check_val("rd_id_tgt", bus.id_ir, rom[6'h20]);
        check_val("rd_pc_next", bus.pc_out, 10'h021);
        tick(1);
        check_val("rd_ex_pc", bus.ex_pc, 10'h020);
        tick(5);
        check_val("rd_retired", bus.retired, 6);
        check_val("rd_sb_left", exp_q.size(), 0);

        // Redirect while a load-use stall is pending
        do_reset();
        rom[0]     = i_type(6'h23, 5'd0, 5'd4, 16'd0);
        rom[1]     = r_type(5'd4, 5'd4, 5'd5, 6'h20);
        rom[6'h10] = i_type(6'h08, 5'd0, 5'd6, 16'd1);
        exp_q.push_back(rom[0]);
        exp_q.push_back(rom[6'h10]);
        bus.run = 1'b1;
        tick(2);
        check_val("rs_stall", bus.stall_out, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h010;
        tick(1);
        bus.redirect_valid = 1'b0;
        check_val("rs_pc", bus.pc_out, 10'h010);
        check_val("rs_id_sq", bus.id_ir, 0);
        check_val("rs_ex_sq", bus.ex_ir, 0);
        tick(7);
        check_val("rs_retired", bus.retired, 2);
        check_val("rs_sb_left", exp_q.size(), 0);

        // Run/step mode
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rom[k] = i_type(6'h08, 5'd0, 5'(k + 1), 16'(k));
            exp_q.push_back(rom[k]);
        end
        bus.run = 1'b1;
        tick(3);
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_val("st_frozen_pc", bus.pc_out, 3);
        end
        check_val("st_frozen_id", bus.id_ir, rom[2]);
        check_val("st_frozen_ex", bus.ex_ir, rom[1]);
        check_val("st_frozen_mem", bus.mem_ir, rom[0]);
        check_val("st_frozen_wb", bus.wb_ir, 0);
        check_val("st_frozen_ret", bus.retired, 0);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        check_val("st_step_pc", bus.pc_out, 4);
        check_val("st_step_id", bus.id_ir, rom[3]);
        check_val("st_step_wb", bus.wb_ir, rom[0]);
        tick(3);
        check_val("st_hold_pc", bus.pc_out, 4);
        bus.step = 1'b1;
        tick(3);
        bus.step = 1'b0;
        check_val("st_multi_pc", bus.pc_out, 7);
        check_val("st_multi_ret", bus.retired, 3);
        check_val("st_multi_wb", bus.wb_ir, rom[3]);
        bus.run = 1'b1;
        tick(6);
        check_val("st_retired", bus.retired, 6);
        check_val("st_sb_left", exp_q.size(), 0);

        // Reset asserted mid-run together with redirect and step
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rom[k] = i_type(6'h08, 5'd0, 5'(k + 1), 16'(k));
            exp_q.push_back(rom[k]);
        end
        bus.run = 1'b1;
        tick(5);
        #2;
        reset              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h155;
        bus.step           = 1'b1;
        #1;
        check_val("mr_pc", bus.pc_out, 0);
        check_val("mr_id", bus.id_ir, 0);
        check_val("mr_ex", bus.ex_ir, 0);
        check_val("mr_mem", bus.mem_ir, 0);
        check_val("mr_wb", bus.wb_ir, 0);
        check_val("mr_ret", bus.retired, 0);
        check_val("mr_ex_pc", bus.ex_pc, 0);
        @(negedge clock);
        check_val("mr_pc_held", bus.pc_out, 0);
        check_val("mr_id_held", bus.id_ir, 0);
        exp_q.delete();
        bus.redirect_valid = 1'b0;
        bus.step           = 1'b0;
        reset              = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(rom[k]);
        tick(1);
        check_val("mr_first_id", bus.id_ir, rom[0]);
        check_val("mr_first_pc", bus.pc_out, 1);
        tick(10);
        check_val("mr_retired", bus.retired, 6);
        check_val("mr_sb_left", exp_q.size(), 0);

        // PC wrap with a 4-bit PC
        do_reset();
        bus4.run = 1'b1;
        tick(15);
        check_val("wr_pc_f", bus4.pc_out, 4'hF);
        tick(1);
        check_val("wr_pc_0", bus4.pc_out, 4'h0);
        tick(1);
        check_val("wr_pc_1", bus4.pc_out, 4'h1);
        bus4.run = 1'b0;

        check_val("final_sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
